arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux.sv | 175 +++++++++++++++++
 tb/tb_arb_mux.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// arb_mux: N-input round-robin arbiter feeding a single registered output
// slot (EMPTY/FULL) with ready/valid handshakes on both sides.
// Optional feature: define ARB_MUX_PRIO_EN to add the fixed_prio input, which
// switches the arbiter to lowest-index-wins without moving the pointer.
module arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN-1:0]         in_valid,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  output logic [NUM_IN-1:0]         in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
`ifdef ARB_MUX_PRIO_EN
  input  logic                      fixed_prio,
`endif
  input  logic                      out_ready
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [SEL_W-1:0]  ptr_r;
  logic [SEL_W-1:0]  start_s;
  logic [SEL_W-1:0]  grant_s;
  logic              found_s;
  logic              load_s;
  logic              upd_ptr_s;
  logic [WIDTH-1:0]  sel_data_s;
  logic [WIDTH-1:0]  data_r;
  logic [SEL_W-1:0]  sel_r;

  assign out_valid = (state_r == FULL);
  assign out_data  = data_r;
  assign out_sel   = sel_r;

  // Load whenever the slot is free or draining and someone offers a word;
  // gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    load_s = rst_n && (!out_valid || out_ready) && (|in_valid);
  end

  // Pick the search start: lowest index in fixed-priority mode, else the pointer.
  always_comb begin
`ifdef ARB_MUX_PRIO_EN
    if (fixed_prio) begin
      start_s   = '0;
      upd_ptr_s = 1'b0;
    end else begin
      start_s   = ptr_r;
      upd_ptr_s = load_s;
    end
`else
    start_s   = ptr_r;
    upd_ptr_s = load_s;
`endif
  end

  // Circular search upward from start_s for the first valid channel.
  always_comb begin
    int idx;
    found_s = 1'b0;
    grant_s = '0;
    idx     = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(start_s) + k;
      if (idx >= NUM_IN) begin
        idx = idx - NUM_IN;
      end else begin
        idx = idx;
      end
      for (int j = 0; j < NUM_IN; j++) begin
        if (!found_s && (j == idx) && in_valid[j]) begin
          found_s = 1'b1;
          grant_s = SEL_W'(j);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // One-hot ready for the granted channel only during a load.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (load_s && found_s && (grant_s == SEL_W'(i))) begin
        in_ready[i] = 1'b1;
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_s == SEL_W'(i)) begin
        sel_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Output slot next state: a load always leaves it FULL, a drain without load empties it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (load_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (load_s) begin
          state_nxt_s = FULL;
        end else if (out_ready) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture word and source index on a load; hold otherwise (covers backpressure).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
      sel_r  <= '0;
    end else if (load_s) begin
      data_r <= sel_data_s;
      sel_r  <= grant_s;
    end else begin
      data_r <= data_r;
      sel_r  <= sel_r;
    end
  end

  // Round-robin pointer moves just past the winner; frozen when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (upd_ptr_s) begin
      if (grant_s == SEL_W'(NUM_IN - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= grant_s + SEL_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed testbench for arb_mux (WIDTH=32, NUM_IN=4, SEL_W=2).
// Define ARB_MUX_PRIO_EN to also exercise the fixed-priority mode.
module tb_arb_mux;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;
`ifdef ARB_MUX_PRIO_EN
  logic                    fixed_prio;
`endif

  int total;
  int bad;

  arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
`ifdef ARB_MUX_PRIO_EN
    .fixed_prio(fixed_prio),
`endif
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed away from any clock edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    in_valid  = 4'hF;
    in_data   = '0;
    out_ready = 1'b1;
    #3;
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 32'h0)  begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (out_sel !== 2'd0)    begin bad++; $display("FAIL reset_sel got=%0d exp=0", out_sel); end
    total++; if (in_ready !== 4'h0)   begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
    in_valid = 4'h0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    in_data = '0;
    in_data[0*WIDTH +: WIDTH] = 32'hDEADBEEF;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1)        begin bad++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
    total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h exp=deadbeef", out_data); end
    total++; if (out_sel !== 2'd0)          begin bad++; $display("FAIL single_sel got=%0d exp=0", out_sel); end
    in_valid = 4'b0000;
    tick();
    total++; if (out_valid !== 1'b0)        begin bad++; $display("FAIL drain_empty got=%0b exp=0", out_valid); end
    tick();
    total++; if (out_data !== 32'hDEADBEEF) begin bad++; $display("FAIL empty_hold_data got=%h exp=deadbeef", out_data); end
    total++; if (out_sel !== 2'd0)          begin bad++; $display("FAIL empty_hold_sel got=%0d exp=0", out_sel); end
  endtask

  task automatic test_round_robin();
    logic [SEL_W-1:0] exp_sel [6];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    pulse_reset();
    for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = 32'(i);
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      total++; if (in_ready !== (4'b0001 << exp_sel[c])) begin bad++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, in_ready, 4'b0001 << exp_sel[c]); end
      tick();
      total++; if (out_sel !== exp_sel[c]) begin bad++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", c, out_sel, exp_sel[c]); end
      total++; if (out_data !== 32'(exp_sel[c])) begin bad++; $display("FAIL rr_data[%0d] got=%h exp=%h", c, out_data, 32'(exp_sel[c])); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%0b exp=1", c, out_valid); end
    end
    in_valid = 4'h0;
    tick();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    in_data = '0;
    in_data[1*WIDTH +: WIDTH] = 32'hF00DCAFE;
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_load_ready got=%b exp=0010", in_ready); end
    tick();
    in_data[1*WIDTH +: WIDTH] = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%0b exp=1", c, out_valid); end
      total++; if (out_data !== 32'hF00DCAFE) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=f00dcafe", c, out_data); end
      total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL bp_sel[%0d] got=%0d exp=1", c, out_sel); end
      tick();
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_wrap();
    pulse_reset();
    in_data = '0;
    in_data[3*WIDTH +: WIDTH] = 32'h33333333;
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    tick();
    total++; if (out_sel !== 2'd3) begin bad++; $display("FAIL wrap_first_sel got=%0d exp=3", out_sel); end
    #1;
    total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL wrap_ready got=%b exp=1000", in_ready); end
    tick();
    total++; if (out_sel !== 2'd3) begin bad++; $display("FAIL wrap_second_sel got=%0d exp=3", out_sel); end
    total++; if (out_data !== 32'h33333333) begin bad++; $display("FAIL wrap_data got=%h exp=33333333", out_data); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_sparse();
    logic [SEL_W-1:0] exp_sel [4];
    exp_sel = '{2'd1, 2'd3, 2'd1, 2'd3};
    pulse_reset();
    for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = 32'hA0 + 32'(i);
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (out_sel !== exp_sel[c]) begin bad++; $display("FAIL sparse_sel[%0d] got=%0d exp=%0d", c, out_sel, exp_sel[c]); end
    end
    // last grant was ch3 -> ptr=0; idle cycles must not move it
    in_valid = 4'b0000;
    tick();
    tick();
    in_valid = 4'b0110;
    tick();
    total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL sparse_ptr_hold got=%0d exp=1", out_sel); end
    total++; if (out_data !== 32'hA1) begin bad++; $display("FAIL sparse_data got=%h exp=a1", out_data); end
    tick();
    total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL sparse_next got=%0d exp=2", out_sel); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    in_data = '0;
    in_data[2*WIDTH +: WIDTH] = 32'hAAAA5555;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_full got=%0b exp=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL mid_data got=%h exp=0", out_data); end
    total++; if (out_sel !== 2'd0)   begin bad++; $display("FAIL mid_sel got=%0d exp=0", out_sel); end
    total++; if (in_ready !== 4'h0)  begin bad++; $display("FAIL mid_ready got=%b exp=0000", in_ready); end
    #1;
    rst_n = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_lost got=%0b exp=0", out_valid); end
    in_valid = 4'b0100;
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_reload_valid got=%0b exp=1", out_valid); end
    total++; if (out_sel !== 2'd2)   begin bad++; $display("FAIL mid_reload_sel got=%0d exp=2", out_sel); end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_first_edge_after_reset();
    in_data = '0;
    in_data[0*WIDTH +: WIDTH] = 32'h0BADF00D;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1)        begin bad++; $display("FAIL post_rst_valid got=%0b exp=1", out_valid); end
    total++; if (out_data !== 32'h0BADF00D) begin bad++; $display("FAIL post_rst_data got=%h exp=0badf00d", out_data); end
    in_valid = 4'b0000;
    tick();
  endtask

`ifdef ARB_MUX_PRIO_EN
  task automatic test_fixed_prio();
    pulse_reset();
    for (int i = 0; i < NUM_IN; i++) in_data[i*WIDTH +: WIDTH] = 32'(i);
    out_ready  = 1'b1;
    fixed_prio = 1'b0;
    in_valid   = 4'b0001;
    tick();  // grant ch0, ptr -> 1
    in_valid   = 4'hF;
    fixed_prio = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL prio_sel[%0d] got=%0d exp=0", c, out_sel); end
    end
    fixed_prio = 1'b0;
    tick();
    total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL prio_resume0 got=%0d exp=1", out_sel); end
    tick();
    total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL prio_resume1 got=%0d exp=2", out_sel); end
    in_valid = 4'h0;
    tick();
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef ARB_MUX_PRIO_EN
    fixed_prio = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_sparse();
    test_reset_mid();
    test_first_edge_after_reset();
`ifdef ARB_MUX_PRIO_EN
    test_fixed_prio();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
